// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_pkg
//  Description : Shared definitions for the systolic operand path: default
//                operand width and array size, the feeder FSM state encoding
//                and the signed lane vector type shared with skew_buffer.
//  Revision    : 1.0  initial release
// ============================================================================
package systolic_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ARRAY_SIZE = 8;

    // One operand lane and one full lane vector at the default geometry.
    typedef logic signed [DEF_DATA_WIDTH-1:0]  lane_t;
    typedef lane_t       [DEF_ARRAY_SIZE-1:0]  lane_vec_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DONE   = 2'd3
    } feeder_state_t;

endpackage : systolic_pkg
`default_nettype wire

// File: rtl/tile_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tile_buffer
//  Description : ARRAY_SIZE x ARRAY_SIZE signed operand register file with a
//                single row write port and a combinational vector read port.
//                The read port returns row rd_idx, or column rd_idx when
//                TILE_FEEDER_TRANSPOSE_EN is defined. A write committing on
//                the same edge is forwarded onto the read port so a stream
//                launched together with a write sees the new row.
//  Ports       : clk, rst          clock / async active-high reset
//                wr_en             write request (already qualified upstream)
//                wr_addr, wr_data  row index and row contents (lane i = col i)
//                rd_idx, rd_data   vector index and selected vector
//  Macros      : TILE_FEEDER_TRANSPOSE_EN - read columns instead of rows
//  Revision    : 1.0  initial release
// ============================================================================
module tile_buffer #(
    parameter  int DATA_WIDTH = 8,
    parameter  int ARRAY_SIZE = 8,
    localparam int ADDR_W     = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      wr_en,
    input  logic [ADDR_W-1:0]                         wr_addr,
    input  logic signed [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]                         rd_idx,
    output logic signed [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] rd_data
);

    localparam logic [ADDR_W:0] c_rows = (ADDR_W+1)'(ARRAY_SIZE);

    // r_tile[row][col]
    logic [ARRAY_SIZE-1:0][ARRAY_SIZE-1:0][DATA_WIDTH-1:0] r_tile;
    logic                                                   w_wr_ok;

    // Rows beyond ARRAY_SIZE-1 are silently dropped.
    assign w_wr_ok = wr_en && ({1'b0, wr_addr} < c_rows);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tile <= '0;
        end else if (w_wr_ok) begin
            r_tile[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
`ifdef TILE_FEEDER_TRANSPOSE_EN
        // Column read: lane i comes from row i; forward a same-edge write of row i.
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            if (w_wr_ok && (wr_addr == ADDR_W'(i))) begin
                rd_data[i] = wr_data[rd_idx];
            end else begin
                rd_data[i] = r_tile[i][rd_idx];
            end
        end
`else
        // Row read: forward the whole row if it is being written this edge.
        if (w_wr_ok && (wr_addr == rd_idx)) begin
            rd_data = wr_data;
        end else begin
            rd_data = r_tile[rd_idx];
        end
`endif
    end

endmodule : tile_buffer
`default_nettype wire

// File: rtl/tile_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tile_feeder
//  Description : Operand feeder ahead of skew_buffer. Holds one N x N signed
//                tile; on start streams N vectors, then N-1 zero vectors to
//                drain the skewed wavefront, then pulses done for one cycle.
//                All outputs except wr_ready are registered; wr_ready is
//                decoded from the state register.
//  Ports       : clk, rst                  clock / async active-high reset
//                wr_en, wr_addr, wr_data   tile row write (IDLE only)
//                wr_ready                  tile writable (state == IDLE)
//                start                     launch a stream (IDLE only)
//                busy, done                sequence status / end pulse
//                enable, data_out          to skew_buffer enable / data_in
//  Macros      : TILE_FEEDER_TRANSPOSE_EN - stream columns instead of rows
//  Revision    : 1.0  initial release
// ============================================================================
module tile_feeder
    import systolic_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int ARRAY_SIZE = DEF_ARRAY_SIZE,
    localparam int ADDR_W     = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         wr_en,
    input  logic [ADDR_W-1:0]                            wr_addr,
    input  logic signed [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] wr_data,
    output logic                                         wr_ready,
    input  logic                                         start,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         enable,
    output logic signed [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] data_out
);

    // Last counter value in STREAM and FLUSH. For N=1 the flush value is
    // never reached because STREAM goes straight to DONE.
    localparam logic [ADDR_W-1:0] c_last_vec   = ADDR_W'(ARRAY_SIZE - 1);
    localparam logic [ADDR_W-1:0] c_last_flush = ADDR_W'(ARRAY_SIZE - 2);

    feeder_state_t                                r_state;
    feeder_state_t                                w_state_nxt;
    logic [ADDR_W-1:0]                            r_cnt;
    logic [ADDR_W-1:0]                            w_cnt_nxt;
    logic                                         r_enable;
    logic                                         r_busy;
    logic                                         r_done;
    logic signed [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] r_data;
    logic                                         w_enable_nxt;
    logic                                         w_busy_nxt;
    logic                                         w_done_nxt;
    logic signed [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] w_data_nxt;
    logic signed [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] w_rd_data;
    logic                                         w_wr_en;

    assign w_wr_en = wr_en && (r_state == ST_IDLE);

    // The read index is the next counter value so that the vector for the
    // upcoming cycle is ready to be registered on this edge.
    tile_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .ARRAY_SIZE (ARRAY_SIZE)
    ) u_tile_buffer (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_idx  (w_cnt_nxt),
        .rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_enable <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_data   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_enable <= w_enable_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_data   <= w_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_STREAM;
                    w_cnt_nxt   = '0;
                end
            end
            ST_STREAM: begin
                if (r_cnt == c_last_vec) begin
                    w_state_nxt = (ARRAY_SIZE == 1) ? ST_DONE : ST_FLUSH;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + ADDR_W'(1);
                end
            end
            ST_FLUSH: begin
                if (r_cnt == c_last_flush) begin
                    w_state_nxt = ST_DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + ADDR_W'(1);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // Registered outputs are decoded from the state being entered.
        w_enable_nxt = (w_state_nxt == ST_STREAM) || (w_state_nxt == ST_FLUSH);
        w_busy_nxt   = (w_state_nxt != ST_IDLE);
        w_done_nxt   = (w_state_nxt == ST_DONE);
        w_data_nxt   = (w_state_nxt == ST_STREAM) ? w_rd_data : '0;
    end

    assign wr_ready = (r_state == ST_IDLE);
    assign busy     = r_busy;
    assign done     = r_done;
    assign enable   = r_enable;
    assign data_out = r_data;

endmodule : tile_feeder
`default_nettype wire

// File: tb/tb_tile_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tile_feeder
//  Description : Self-checking bench for tile_feeder (N=8 main instance plus
//                an N=1 instance). A cycle-phase model of the feeder checks
//                all outputs every falling edge; directed literal checks pin
//                the model. Honours TILE_FEEDER_TRANSPOSE_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tile_feeder;

    localparam int N  = 8;
    localparam int DW = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               wr_en;
    logic [2:0]         wr_addr;
    logic [N-1:0][DW-1:0] wr_data;
    logic               wr_ready;
    logic               start;
    logic               busy;
    logic               done;
    logic               enable;
    logic [N-1:0][DW-1:0] data_out;

    // N = 1 instance
    logic               rst1;
    logic               wr_en1;
    logic [0:0]         wr_addr1;
    logic [0:0][DW-1:0] wr_data1;
    logic               wr_ready1;
    logic               start1;
    logic               busy1;
    logic               done1;
    logic               enable1;
    logic [0:0][DW-1:0] data_out1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tile_feeder #(.DATA_WIDTH(DW), .ARRAY_SIZE(N)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .start(start), .busy(busy), .done(done),
        .enable(enable), .data_out(data_out)
    );

    tile_feeder #(.DATA_WIDTH(DW), .ARRAY_SIZE(1)) dut1 (
        .clk(clk), .rst(rst1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .wr_ready(wr_ready1), .start(start1), .busy(busy1), .done(done1),
        .enable(enable1), .data_out(data_out1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: the tile as a plain array plus the number of cycles elapsed
    // since the accepted start (0 = idle, 1..2N = active sequence).
    // ------------------------------------------------------------------
    logic [DW-1:0] m_tile [N][N];
    int            m_phase;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    m_tile[r][c] = '0;
        end else if (m_phase == 0) begin
            if (wr_en && (int'(wr_addr) < N))
                for (int c = 0; c < N; c++)
                    m_tile[wr_addr][c] = wr_data[c];
            if (start) m_phase = 1;
        end else if (m_phase == 2 * N) begin
            m_phase = 0;
        end else begin
            m_phase = m_phase + 1;
        end
    end

    function automatic logic [63:0] m_vec(input int k);
        logic [N-1:0][DW-1:0] v;
        for (int i = 0; i < N; i++) begin
`ifdef TILE_FEEDER_TRANSPOSE_EN
            v[i] = m_tile[i][k];
`else
            v[i] = m_tile[k][i];
`endif
        end
        return 64'(v);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            logic [63:0] exp_data;
            exp_data = (m_phase >= 1 && m_phase <= N) ? m_vec(m_phase - 1) : 64'd0;
            chk("wr_ready", 64'(wr_ready), 64'(m_phase == 0));
            chk("busy",     64'(busy),     64'(m_phase != 0));
            chk("done",     64'(done),     64'(m_phase == 2 * N));
            chk("enable",   64'(enable),   64'(m_phase >= 1 && m_phase <= 2 * N - 1));
            chk("data_out", 64'(data_out), exp_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch a stream (any wr_* already set is applied on the start edge),
    // optionally disturb it at cycle dcyc, and walk to cycle 2N+1.
    task automatic run_stream(input string tag, input int dcyc, input logic [63:0] exp_first);
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        for (int cyc = 1; cyc <= 2 * N + 1; cyc++) begin
            if (cyc == 1) begin
                chk({tag, "_first_vec"}, 64'(data_out), exp_first);
                chk({tag, "_first_en"}, 64'(enable), 64'd1);
            end
            if (cyc == dcyc) begin
                start   = 1'b1;
                wr_en   = 1'b1;
                wr_addr = 3'd0;
                wr_data = '1;
            end else if (cyc == dcyc + 1) begin
                start = 1'b0;
                wr_en = 1'b0;
            end
            if (cyc == 2 * N - 1) chk({tag, "_last_flush_en"}, 64'(enable), 64'd1);
            if (cyc == 2 * N)     chk({tag, "_done"}, 64'(done), 64'd1);
            if (cyc == 2 * N + 1) chk({tag, "_ready_back"}, 64'(wr_ready), 64'd1);
            if (cyc <= 2 * N) tick();
        end
    endtask

`ifdef TILE_FEEDER_TRANSPOSE_EN
    localparam logic [63:0] c_first_ramp = 64'h3830282018100800;
    localparam logic [63:0] c_first_m128 = 64'h3830282018100880;
`else
    localparam logic [63:0] c_first_ramp = 64'h0706050403020100;
    localparam logic [63:0] c_first_m128 = 64'h8080808080808080;
`endif

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
        rst1 = 1'b1; wr_en1 = 1'b0; wr_addr1 = '0; wr_data1 = '0; start1 = 1'b0;
        tick();
        tick();
        chk("rst_ready",  64'(wr_ready), 64'd1);
        chk("rst_enable", 64'(enable),   64'd0);
        chk("rst_busy",   64'(busy),     64'd0);
        chk("rst_data",   64'(data_out), 64'd0);
        rst = 1'b0;
        tick();

        // Ramp tile tile[r][c] = r*N + c
        for (int r = 0; r < N; r++) begin
            wr_en   = 1'b1;
            wr_addr = 3'(r);
            for (int c = 0; c < N; c++) wr_data[c] = 8'(r * N + c);
            tick();
        end
        wr_en = 1'b0;
        run_stream("ramp", 0, c_first_ramp);

        // Start + write in the middle of a stream are ignored; then replay.
        run_stream("disturb", 5, c_first_ramp);
        tick();
        run_stream("replay", 0, c_first_ramp);

        // Same-cycle write of row 0 and start.
        wr_en   = 1'b1;
        wr_addr = 3'd0;
        wr_data = {N{8'h80}};
        run_stream("samecyc", 0, c_first_m128);

        // Asynchronous reset during stream cycle 4.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        chk("arst_enable", 64'(enable),   64'd0);
        chk("arst_data",   64'(data_out), 64'd0);
        chk("arst_busy",   64'(busy),     64'd0);
        chk("arst_ready",  64'(wr_ready), 64'd1);
        tick();
        rst = 1'b0;
        tick();
        run_stream("zero_tile", 0, 64'd0);

        // Randomized traffic, checked by the per-cycle model.
        for (int i = 0; i < 1500; i++) begin
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_addr = 3'($urandom_range(0, N - 1));
            wr_data = {$urandom, $urandom};
            start   = ($urandom_range(0, 7) == 0);
            tick();
        end
        wr_en = 1'b0;
        start = 1'b0;
        repeat (2 * N + 2) tick();

        // N = 1 instance: stream of one vector, no flush.
        rst1 = 1'b0;
        tick();
        chk("n1_rst_ready", 64'(wr_ready1), 64'd1);
        wr_en1   = 1'b1;
        wr_addr1 = 1'b0;
        wr_data1 = 8'd5;
        tick();
        wr_en1 = 1'b0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("n1_c1_data", 64'(data_out1), 64'd5);
        chk("n1_c1_en",   64'(enable1),   64'd1);
        chk("n1_c1_done", 64'(done1),     64'd0);
        tick();
        chk("n1_c2_done", 64'(done1),     64'd1);
        chk("n1_c2_en",   64'(enable1),   64'd0);
        chk("n1_c2_busy", 64'(busy1),     64'd1);
        chk("n1_c2_data", 64'(data_out1), 64'd0);
        tick();
        chk("n1_c3_ready", 64'(wr_ready1), 64'd1);
        chk("n1_c3_busy",  64'(busy1),     64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_tile_feeder
`default_nettype wire

// File: doc/tile_feeder.md
# tile_feeder

Operand feeder directly upstream of `skew_buffer`. It holds one ARRAY_SIZE×ARRAY_SIZE signed operand tile, loaded one row per write. On `start` it streams the tile one vector per cycle into the skew buffer's `data_in`/`enable`. It then drives zero vectors for ARRAY_SIZE-1 cycles so the skewed wavefront fully drains through the systolic array, and signals completion with a one-cycle `done` pulse.

## Interface
- `DATA_WIDTH`, 8, signed operand width; must match `skew_buffer`.
- `ARRAY_SIZE`, 8, tile dimension N (rows = columns = skew lanes); N ≥ 1.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  write one tile row this cycle; effective only when `wr_ready`=1.
- `wr_addr`  in  $clog2(ARRAY_SIZE) (min 1)  row index 0..N-1; out-of-range writes are dropped.
- `wr_data`  in  signed DATA_WIDTH × [ARRAY_SIZE-1:0]  row contents, lane i = column i.
- `wr_ready`  out  1  tile buffer writable; equals state==IDLE.
- `start`  in  1  begin streaming; sampled only in IDLE, ignored otherwise.
- `busy`  out  1  high from the cycle after an accepted start through the DONE cycle.
- `done`  out  1  one-cycle pulse at end of drain.
- `enable`  out  1  drives `skew_buffer.enable`.
- `data_out`  out  signed DATA_WIDTH × [ARRAY_SIZE-1:0]  drives `skew_buffer.data_in`.

## Operation
- FSM states: IDLE, STREAM, FLUSH, DONE.
  - IDLE → STREAM on `start`.
  - STREAM → FLUSH after N vectors; STREAM → DONE directly when N=1.
  - FLUSH → DONE after N-1 zero vectors.
  - DONE → IDLE unconditionally.
- Vector counter counts 0..N-1 in STREAM and 0..N-2 in FLUSH, and clears on every state change.
- STREAM vector k: `data_out[i]` = tile[k][i], i.e. row k.
- FLUSH: `data_out` is all zeros and `enable`=1.
- IDLE and DONE: `enable`=0 and `data_out` holds zero.
- The tile is retained after DONE, so a second `start` without rewriting replays an identical stream.
- `wr_en` and `start` in the same IDLE cycle: the write commits on that edge, and the stream reads the updated tile.
- `wr_en` outside IDLE: ignored, tile unchanged.
- `start` outside IDLE: ignored; it is neither queued nor able to restart the sequence.
- No arithmetic; values pass through bit-exact, with no widening or saturation.

## Timing
- All outputs are registered. `wr_ready` is decoded directly from the state register.
- `start` accepted at edge T. Cycles counted after T:
  - cycles 1..N: `enable`=1, vector k-1.
  - cycles N+1..2N-1: `enable`=1, zero vectors.
  - cycle 2N: `done`=1, `busy`=1, `enable`=0.
  - cycle 2N+1: IDLE, `wr_ready`=1, and a new start is accepted.
- Start-to-start minimum: 2N+1 cycles.
- Write latency: row visible to a stream started in the same or any later cycle.
- Reset values:
  - state IDLE, counter 0.
  - tile buffer all zeros.
  - `enable`, `busy`, `done` = 0; `data_out` all zeros; `wr_ready` = 1.
- Reset mid-stream: outputs zero immediately (async) and the stream is abandoned. After reset release, the block sits in IDLE with a zeroed tile.

## Configuration
- `TILE_FEEDER_TRANSPOSE_EN` defined: the STREAM vector k is column k, so `data_out[i]` = tile[i][k]. This feeds B-operand tiles stored row-major.
- Undefined: row streaming as above.
- The macro has no effect on timing, FSM, or flush length.

## Structure
- Shared package `systolic_pkg`:
  - default DATA_WIDTH / ARRAY_SIZE constants.
  - `feeder_state_t` enum.
  - the signed lane vector typedef shared with `skew_buffer`.
- Sub-module `tile_buffer`:
  - N×N signed register file, async-reset to zero.
  - one row write port.
  - one combinational read port selecting row k, or column k under the macro.
  - `tile_feeder` registers the read result onto `data_out`.

## Test plan
- Reset, then write rows r with tile[r][c]=r*N+c (N=8) and start → cycles 1..8 after start show rows 0..7, cycles 9..15 show zeros with `enable`=1, `done` pulses at cycle 16, and `wr_ready` returns at cycle 17.
- Same stimulus with `TILE_FEEDER_TRANSPOSE_EN` → cycle 1 `data_out` = {56,48,…,8,0} at lanes 7..0 (column 0); the rest follows transposed.
- Pulse `start` and `wr_en` at cycle 5 of a stream → the stream is unaltered, `done` still arrives at cycle 16, and a replay reproduces the original tile.
- Same-cycle `wr_en` (row 0, all -128) and `start` in IDLE → the first vector is all -128.
- Assert `rst` at stream cycle 4 → `enable`/`data_out`/`busy` go zero at once. After release, a start with no writes streams 8 zero vectors plus 7 flush vectors.
- N=1: write 5, start → cycle 1 gives 5 with `enable`=1, `done` at cycle 2, no flush vectors.
